// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: pipeline control for the F/D/E/M stages of the RV32IM core.
//
// Drives per-stage stall and kill signals, the fetch PC force, and the operand
// forwarding selects. It also tracks outstanding long-latency (MUL/DIV)
// writebacks in a per-register scoreboard and counts branch mispredicts.
//
// Ports:
//   clk_i, rst_i                  clock; synchronous active-high reset
//   boot_addr_i                   PC forced during the boot window
//   {f,d,e,m}_stall_req_i         stage-local stall requests
//   {f,d,e,m}_valid_i             stage valid flags
//   f_cu_rs{1,2}_addr/req_i       consumer sources in F
//   {d,e}_cu_rd_addr/we_i         producer destinations in D and E
//   {d,e}_load_i                  producer is a load
//   e_lu_issue_i                  E issues a long-latency op to e_cu_rd_addr_i
//   lu_done_i, lu_rd_addr_i       long-latency writeback
//   m_prediction_i, m_br_j_taken_i predicted / resolved branch direction
//   m_target_pc_i, m_next_pc_i    redirect candidates
//   cu_stall_*_o, cu_kill_*_o     per-stage stall and kill
//   cu_force_pc_o, cu_force_f_o   fetch PC override
//   cu_fwd_rs{1,2}_sel_o          00 regfile, 01 D result, 10 E result
//   cu_mispredict_cnt_o           saturating mispredict count
module rv_hazard_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned GPR_ADDR_W  = 5,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned FWD_EN      = 1,
    parameter int unsigned LU_MAX      = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       boot_addr_i,
    input  logic                  f_stall_req_i,
    input  logic                  d_stall_req_i,
    input  logic                  e_stall_req_i,
    input  logic                  m_stall_req_i,
    input  logic                  f_valid_i,
    input  logic                  d_valid_i,
    input  logic                  e_valid_i,
    input  logic                  m_valid_i,
    input  logic [GPR_ADDR_W-1:0] f_cu_rs1_addr_i,
    input  logic [GPR_ADDR_W-1:0] f_cu_rs2_addr_i,
    input  logic                  f_cu_rs1_req_i,
    input  logic                  f_cu_rs2_req_i,
    input  logic [GPR_ADDR_W-1:0] d_cu_rd_addr_i,
    input  logic [GPR_ADDR_W-1:0] e_cu_rd_addr_i,
    input  logic                  d_cu_rd_we_i,
    input  logic                  e_cu_rd_we_i,
    input  logic                  d_load_i,
    input  logic                  e_load_i,
    input  logic                  e_lu_issue_i,
    input  logic                  lu_done_i,
    input  logic [GPR_ADDR_W-1:0] lu_rd_addr_i,
    input  logic                  m_prediction_i,
    input  logic                  m_br_j_taken_i,
    input  logic [XLEN-1:0]       m_target_pc_i,
    input  logic [XLEN-1:0]       m_next_pc_i,
    output logic                  cu_stall_f_o,
    output logic                  cu_stall_d_o,
    output logic                  cu_stall_e_o,
    output logic                  cu_stall_m_o,
    output logic                  cu_kill_f_o,
    output logic                  cu_kill_d_o,
    output logic                  cu_kill_e_o,
    output logic                  cu_kill_m_o,
    output logic [XLEN-1:0]       cu_force_pc_o,
    output logic                  cu_force_f_o,
    output logic [1:0]            cu_fwd_rs1_sel_o,
    output logic [1:0]            cu_fwd_rs2_sel_o,
    output logic [CNT_W-1:0]      cu_mispredict_cnt_o
);

    localparam int unsigned NREGS  = 1 << GPR_ADDR_W;
    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned OUT_W  = $clog2(LU_MAX + 1);
    localparam logic [BOOT_W-1:0] BOOT_END = BOOT_W'(BOOT_CYCLES);
    localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(LU_MAX);

    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

    logic in_boot, mispredict;
    logic rs1_rd, rs2_rd, d_prod, e_prod;
    logic d_hit1, d_hit2, e_hit1, e_hit2;
    logic raw_stall, sb_stall, lu_issue, waw_clear, lu_block, lu_accept;
    logic stall_m, stall_e, stall_d, stall_f;

    // Reset counts as part of the boot window so the force is also held in reset.
    assign in_boot    = rst_i | (boot_cnt_q < BOOT_END);
    assign mispredict = m_valid_i & (m_prediction_i ^ m_br_j_taken_i) & ~in_boot;

    assign rs1_rd = f_cu_rs1_req_i & f_valid_i;
    assign rs2_rd = f_cu_rs2_req_i & f_valid_i;
    assign d_prod = d_cu_rd_we_i & d_valid_i & (d_cu_rd_addr_i != '0);
    assign e_prod = e_cu_rd_we_i & e_valid_i & (e_cu_rd_addr_i != '0);
    assign d_hit1 = rs1_rd & d_prod & (f_cu_rs1_addr_i == d_cu_rd_addr_i);
    assign d_hit2 = rs2_rd & d_prod & (f_cu_rs2_addr_i == d_cu_rd_addr_i);
    assign e_hit1 = rs1_rd & e_prod & (f_cu_rs1_addr_i == e_cu_rd_addr_i);
    assign e_hit2 = rs2_rd & e_prod & (f_cu_rs2_addr_i == e_cu_rd_addr_i);

    always_comb begin
        raw_stall        = 1'b0;
        cu_fwd_rs1_sel_o = 2'b00;
        cu_fwd_rs2_sel_o = 2'b00;
        if (FWD_EN != 0) begin
            // Only a load result is not yet available for forwarding.
            raw_stall = (d_load_i & (d_hit1 | d_hit2)) | (e_load_i & (e_hit1 | e_hit2));
            if (!rst_i) begin
                cu_fwd_rs1_sel_o = d_hit1 ? 2'b01 : (e_hit1 ? 2'b10 : 2'b00);
                cu_fwd_rs2_sel_o = d_hit2 ? 2'b01 : (e_hit2 ? 2'b10 : 2'b00);
            end
        end else begin
            raw_stall = d_hit1 | d_hit2 | e_hit1 | e_hit2;
        end
    end

    // Pending bits are registered, so a same-cycle done still stalls the reader.
    assign sb_stall  = (rs1_rd & pend_q[f_cu_rs1_addr_i]) | (rs2_rd & pend_q[f_cu_rs2_addr_i]);
    assign lu_issue  = e_lu_issue_i & e_valid_i;
    assign waw_clear = lu_done_i & (lu_rd_addr_i == e_cu_rd_addr_i);
    assign lu_block  = lu_issue & (((out_cnt_q == OUT_MAX) & ~lu_done_i) |
                                   (pend_q[e_cu_rd_addr_i] & ~waw_clear));

    assign stall_m = m_stall_req_i;
    assign stall_e = stall_m | e_stall_req_i | lu_block;
    assign stall_d = stall_e | d_stall_req_i;
    assign stall_f = stall_d | f_stall_req_i | raw_stall | sb_stall;

    assign cu_stall_m_o = stall_m;
    assign cu_stall_e_o = stall_e;
    assign cu_stall_d_o = stall_d;
    assign cu_stall_f_o = stall_f;

    assign cu_kill_f_o = mispredict;
    assign cu_kill_d_o = mispredict;
    assign cu_kill_e_o = mispredict;
    assign cu_kill_m_o = mispredict;

    assign cu_force_f_o  = in_boot | mispredict;
    assign cu_force_pc_o = in_boot ? boot_addr_i :
                           (m_br_j_taken_i ? m_target_pc_i : m_next_pc_i);

    assign cu_mispredict_cnt_o = mp_cnt_q;

    assign lu_accept = lu_issue & ~mispredict & ~stall_e;

    always_comb begin
        boot_cnt_d = boot_cnt_q;
        pend_d     = pend_q;
        out_cnt_d  = out_cnt_q;
        mp_cnt_d   = mp_cnt_q;

        if (boot_cnt_q < BOOT_END) begin
            boot_cnt_d = boot_cnt_q + 1'b1;
        end

        // Clear before set: a same-register set and clear leaves the bit set.
        if (lu_done_i) begin
            pend_d[lu_rd_addr_i] = 1'b0;
        end
        if (lu_accept && (e_cu_rd_addr_i != '0)) begin
            pend_d[e_cu_rd_addr_i] = 1'b1;
        end

        unique case ({lu_accept, lu_done_i && (out_cnt_q != '0)})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_cnt_q <= '0;
            pend_q     <= '0;
            out_cnt_q  <= '0;
            mp_cnt_q   <= '0;
        end else begin
            boot_cnt_q <= boot_cnt_d;
            pend_q     <= pend_d;
            out_cnt_q  <= out_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
        end
    end

endmodule

// File: doc/rv_hazard_ctrl.md
# rv_hazard_ctrl

Parametrised pipeline control unit for the RV32IM core. It replaces the fixed stall-only hazard logic with several additions:
- a configurable boot-redirect sequence;
- optional operand forwarding with load-use detection;
- a scoreboard that tracks long-latency (MUL/DIV) writebacks;
- a saturating mispredict counter.

It sits beside the F/D/E/M stages and drives their stall, kill and PC-force inputs.

## Interface
- XLEN, 32, datapath and PC width
- GPR_ADDR_W, 5, register address width; scoreboard has 2**GPR_ADDR_W entries
- BOOT_CYCLES, 2, cycles of boot-address force after reset release (>=1)
- FWD_EN, 1, 1: forward from D/E producers, stall only on load-use; 0: stall on any D/E RAW
- LU_MAX, 4, maximum outstanding long-latency ops (>=1)
- CNT_W, 32, mispredict counter width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- boot_addr_i  in  XLEN  boot PC
- f/d/e/m_stall_req_i  in  1 each  stage-local stall requests
- f/d/e/m_valid_i  in  1 each  stage valid
- f_cu_rs1_addr_i, f_cu_rs2_addr_i  in  GPR_ADDR_W  consumer source registers
- f_cu_rs1_req_i, f_cu_rs2_req_i  in  1  source actually read
- d_cu_rd_addr_i, e_cu_rd_addr_i  in  GPR_ADDR_W  producer destinations
- d_cu_rd_we_i, e_cu_rd_we_i  in  1  producer writes rd
- d_load_i, e_load_i  in  1  producer is a load
- e_lu_issue_i  in  1  E issues long-latency op writing e_cu_rd_addr_i
- lu_done_i  in  1  long-latency unit writes back this cycle
- lu_rd_addr_i  in  GPR_ADDR_W  register written back
- m_prediction_i, m_br_j_taken_i  in  1  predicted / actual direction
- m_target_pc_i, m_next_pc_i  in  XLEN  redirect candidates
- cu_stall_f/d/e/m_o  out  1 each  stage stall
- cu_kill_f/d/e/m_o  out  1 each  stage kill
- cu_force_pc_o  out  XLEN  forced PC
- cu_force_f_o  out  1  force fetch PC
- cu_fwd_rs1_sel_o, cu_fwd_rs2_sel_o  out  2  00 regfile, 01 D result, 10 E result
- cu_mispredict_cnt_o  out  CNT_W  saturating mispredict count

## Operation
- Boot: a counter counts 0..BOOT_CYCLES-1 after reset release. While it has not reached BOOT_CYCLES:
  - cu_force_f_o=1 and cu_force_pc_o=boot_addr_i;
  - mispredicts are ignored (no kill, no count).
- RAW match on a source s against producer P (D or E) requires all of:
  - rs_req & f_valid;
  - P_we & P_valid;
  - rs_addr == P_rd;
  - P_rd != 0.
- With FWD_EN=0, any RAW match stalls F and the forward selects stay 00.
- With FWD_EN=1:
  - A D match stalls F only if d_load_i.
  - An E match stalls F only if e_load_i.
  - Otherwise the select is 01 for a D match, else 10 for an E match (D wins over E), else 00.
  - The selects are driven even while F is stalled.
- Scoreboard: one pending bit per register (bit 0 never set) plus an outstanding counter (0..LU_MAX).
  - Set bit on e_lu_issue_i & e_valid_i & ~cu_kill_e_o & ~cu_stall_e_o; clear bit on lu_done_i.
  - A set and a clear of the same register in the same cycle leaves the bit set; the counter is unchanged (+1 -1).
  - A source whose pending bit is set (rs_req & f_valid) stalls F. Forwarding never overrides this stall.
  - The issue stalls E (cu_stall_e_o) when the counter == LU_MAX and there is no same-cycle done.
  - The issue also stalls E when the rd bit is already pending and that register is not cleared in the same cycle (WAW).
- Stall cascade:
  - stall_m = m_req.
  - stall_e = stall_m | e_req | lu_block.
  - stall_d = stall_e | d_req.
  - stall_f = stall_d | f_req | raw_stall | sb_stall.
- Mispredict = m_valid & (m_prediction ^ m_br_j_taken) & ~boot.
  - Kills all four stages.
  - Asserts cu_force_f_o.
  - cu_force_pc_o = taken ? target : next.
- Mispredict counter: increments on each mispredict cycle and saturates at all-ones.
- Outputs that are not otherwise specified: force_pc follows the taken ? target : next mux outside boot.

## Timing
- While rst_i=1, all registers are cleared: boot counter=0, scoreboard=0, outstanding counter=0, mispredict counter=0.
- During reset:
  - cu_force_f_o=1 and cu_force_pc_o=boot_addr_i;
  - kills=0 and fwd sels=00;
  - stalls follow the inputs combinationally.
- After reset release, force is held for exactly BOOT_CYCLES clock edges.
- Stall, kill and fwd outputs are combinational (zero latency).
- A scoreboard set or clear is visible as a stall on the cycle after the edge.
- A done and a consumer read in the same cycle still stall that cycle; the read proceeds the next cycle.
- A reset asserted mid-operation drops all pending bits; no done is required afterwards.

## Test plan
- Reset with BOOT_CYCLES=3, boot_addr=0x8000_0000 -> force_f=1 for 3 cycles after release with pc=0x8000_0000; a mispredict injected in cycle 2 is ignored and the counter stays 0.
- FWD_EN=1, F reads x5, D writes x5 (not a load) -> rs1_sel=01, no stall; set d_load_i=1 -> stall_f=1, stall_d=0.
- FWD_EN=1, D and E both write x7, F reads x7 in rs2 -> rs2_sel=01; F reads x0 with D writing x0 -> sel=00, no stall.
- Issue DIV to x10 -> F reading x10 stalls until the cycle after lu_done_i with lu_rd_addr=10; a second issue to x10 before the done -> stall_e=1.
- LU_MAX=2: issue to x1 and x2, then a third issue to x3 -> stall_e=1; lu_done_i for x1 in the same cycle -> the issue is accepted and the counter stays 2.
- Mispredict with predicted=0, taken=1, target=0x100 -> all kills=1, force_pc=0x100, counter+1; a simultaneous e_lu_issue_i is not recorded.
